mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage plus MEM/WB register for the five-stage CPU. Sits downstream of the EX/MEM register: it runs loads and stores over a dedicated Wishbone master port, holds the pipeline with a stall request while a bus cycle is outstanding, and registers the write-back data, destination register and RegWrite for the WB stage and the regfile write port.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- in_alu_result  in  ADDR_WIDTH  ALU result: effective address for loads/stores, otherwise the write-back value.
- in_store_data  in  DATA_WIDTH  rs2 value, already forwarded.
- in_rd  in  5  destination register.
- in_MemRead, in_MemWrite, in_MemtoReg, in_RegWrite  in  1 each  control bits from EX/MEM.
- in_MemSize  in  1  0 = word, 1 = byte.
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM while high.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_sel_o  out  DATA_WIDTH/8  byte enables.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone ack.
- memwb_valid, memwb_RegWrite  out  1  to WB stage.
- memwb_rd  out  5  regfile write address.
- memwb_wdata  out  DATA_WIDTH  regfile write data.

## Operation
- mem_op = in_valid & (in_MemRead | in_MemWrite). If in_MemRead and in_MemWrite are both high, the access is a read.
- FSM states:
  - IDLE: if mem_op, register the bus request, assert cyc/stb, and go to ACCESS.
  - ACCESS: hold all bus outputs stable until wb_ack_i. On ack, latch wb_dat_i for a read, drop cyc/stb and we, and go to DONE.
  - DONE: load the MEM/WB register, then go to IDLE.
- stall_o = mem_op & (state != DONE). It is combinational, so it is high during the IDLE cycle that starts the access. Upstream inputs are stable while stall_o is high.
- Non-memory instructions and bubbles never leave IDLE. The MEM/WB register loads every cycle in which stall_o is 0.
- Address: wb_adr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Byte enables and data:
  - Word: sel = 4'hF and wb_dat_o = store data. addr[1:0] is ignored, with no misalignment trap.
  - Byte: sel = 1 << addr[1:0] and wb_dat_o = store byte replicated on all four lanes.
- Load result:
  - Word: the latched word.
  - Byte: the lane at addr[1:0], sign-extended to 32 bits (LB).
- memwb_wdata = in_MemtoReg ? load result : in_alu_result.
- memwb_valid = in_valid and memwb_RegWrite = in_valid & in_RegWrite. rd passes through unchanged; the x0 write guard is in regfile.
- Cycles in which the MEM/WB register does not load (stall_o high): memwb_valid = 0 and memwb_RegWrite = 0, so no write-back happens twice.

## Timing
- Reset (asynchronous, active-low) forces state = IDLE, all wb_* outputs = 0, and all memwb_* = 0, immediately and independent of clk. A bus cycle interrupted by reset is abandoned; a late ack after reset is ignored in IDLE.
- Non-memory latency: 1 cycle from EX/MEM to MEM/WB.
- Memory latency: 2 + N cycles, where N = cycles from cyc/stb assertion to ack inclusive. With a zero-wait slave, ack arrives in the first ACCESS cycle: stall_o is high for 2 cycles and MEM/WB updates on the 3rd edge.
- Bus rules:
  - cyc_o and stb_o are always equal.
  - adr/dat/sel/we are stable from assertion until the ack cycle.
  - No back-to-back cycles: at least one idle cycle (DONE) between accesses.
- Back-to-back memory instructions: the second one is seen in IDLE on the cycle after DONE, because EX/MEM advanced on the DONE edge.
- wb_ack_i is ignored outside ACCESS.

## Structure
- Shared package cpu_pkg:
  - mem_state_t enum {IDLE, ACCESS, DONE}.
  - MEM_SIZE_WORD = 1'b0, MEM_SIZE_BYTE = 1'b1.
  - REG_ADDR_W = 5.
- Sub-module mem_align: combinational lane steering. It produces sel and write-data replication from size/addr/store data, and byte extraction plus sign extension from size/addr/read word. The FSM and registers stay in mem_access_stage.

## Test plan
- Reset mid-ACCESS: assert reset (low) with cyc high → cyc/stb/we/sel and memwb_* are 0 the same cycle; a later ack changes nothing.
- ALU op, alu_result=0x0000_1234, rd=5, RegWrite=1, MemtoReg=0 → stall_o never rises; next edge gives memwb_rd=5, memwb_wdata=0x0000_1234, memwb_RegWrite=1.
- LW at 0x8000_0104, zero-wait slave returns 0xDEAD_BEEF → adr=0x8000_0104, sel=F, we=0; stall_o high for 2 cycles; memwb_wdata=0xDEAD_BEEF on the 3rd edge.
- LB at 0x8000_0107, read word 0x80FF_0011 → sel=4'b1000, memwb_wdata=0xFFFF_FF80. LB at offset 0 of the same word → 0x0000_0011.
- SB at 0x8000_0002 with store data 0x0000_00A5, 3 wait states → dat_o=0xA5A5_A5A5, sel=4'b0100, we=1, all held stable for 4 cycles; memwb_RegWrite=0.
- SW followed immediately by LW → two separate bus cycles with cyc low for at least 1 cycle between them; the load data matches the stored value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline.
//   mem_state_t   : MEM-stage bus sequencer states
//   MEM_SIZE_*    : encoding of the MemSize control bit
//   REG_ADDR_W    : register-file address width
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic MEM_SIZE_WORD = 1'b0;
    localparam logic MEM_SIZE_BYTE = 1'b1;

    localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for the MEM stage.
// Ports:
//   size_i        : access size (MEM_SIZE_WORD / MEM_SIZE_BYTE)
//   lane_i        : byte offset within the bus word (addr[1:0])
//   store_data_i  : store value from the pipeline
//   rdata_i       : word returned by the bus
//   sel_o         : Wishbone byte enables
//   wdata_o       : Wishbone write data (byte replicated on every lane)
//   load_data_o   : load result (word, or sign-extended byte)
module mem_align
    import cpu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int LANE_W     = $clog2(BYTES)
) (
    input  logic                  size_i,
    input  logic [LANE_W-1:0]     lane_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [BYTES-1:0]      sel_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] load_data_o
);

    logic [7:0] rd_byte;

    always_comb begin
        rd_byte     = rdata_i[{lane_i, 3'b000} +: 8];
        sel_o       = '1;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        if (size_i == MEM_SIZE_BYTE) begin
            sel_o       = BYTES'(1) << lane_i;
            wdata_o     = {BYTES{store_data_i[7:0]}};
            load_data_o = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage plus MEM/WB register.
// Runs loads/stores over a Wishbone master port, requests a pipeline stall
// while a bus cycle is outstanding, and registers write-back data, rd and
// RegWrite for the WB stage.
// Ports:
//   clk, reset (async, active-low)
//   in_*            : EX/MEM register contents
//   stall_o         : hold PC, IF/ID, ID/EX and EX/MEM
//   wb_*            : Wishbone master (cyc, stb, we, adr, dat, sel / dat_i, ack_i)
//   memwb_*         : MEM/WB register outputs
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_alu_result,
    input  logic [DATA_WIDTH-1:0]   in_store_data,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic                    in_MemRead,
    input  logic                    in_MemWrite,
    input  logic                    in_MemtoReg,
    input  logic                    in_RegWrite,
    input  logic                    in_MemSize,
    output logic                    stall_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    output logic                    memwb_valid,
    output logic                    memwb_RegWrite,
    output logic [REG_ADDR_W-1:0]   memwb_rd,
    output logic [DATA_WIDTH-1:0]   memwb_wdata
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);

    mem_state_t              state_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [BYTES-1:0]        sel_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    memwb_valid_q;
    logic                    memwb_rw_q;
    logic [REG_ADDR_W-1:0]   memwb_rd_q;
    logic [DATA_WIDTH-1:0]   memwb_wdata_q;
    logic [DATA_WIDTH-1:0]   memwb_wdata_d;

    logic                    mem_op;
    logic                    is_write;
    logic [BYTES-1:0]        align_sel;
    logic [DATA_WIDTH-1:0]   align_wdata;
    logic [DATA_WIDTH-1:0]   load_data;

    assign mem_op   = in_valid & (in_MemRead | in_MemWrite);
    // MemRead wins when both control bits are set.
    assign is_write = in_MemWrite & ~in_MemRead;

    // Combinational so the pipeline is held in the IDLE cycle that launches
    // the access; released in DONE so EX/MEM advances on the DONE edge.
    assign stall_o  = mem_op & (state_q != DONE);

    mem_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size_i       (in_MemSize),
        .lane_i       (in_alu_result[LANE_W-1:0]),
        .store_data_i (in_store_data),
        .rdata_i      (rdata_q),
        .sel_o        (align_sel),
        .wdata_o      (align_wdata),
        .load_data_o  (load_data)
    );

    // Bus sequencer with registered Wishbone outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        cyc_q   <= 1'b1;
                        we_q    <= is_write;
                        adr_q   <= {in_alu_result[ADDR_WIDTH-1:2], 2'b00};
                        dat_q   <= align_wdata;
                        sel_q   <= align_sel;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wb_ack_i) begin
                        if (!we_q) begin
                            rdata_q <= wb_dat_i;
                        end
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign memwb_wdata_d = in_MemtoReg ? load_data : DATA_WIDTH'(in_alu_result);

    // MEM/WB register: loads whenever the stage is not stalling; stalled
    // cycles emit a bubble so a write-back is never repeated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwb_valid_q <= 1'b0;
            memwb_rw_q    <= 1'b0;
            memwb_rd_q    <= '0;
            memwb_wdata_q <= '0;
        end else if (!stall_o) begin
            memwb_valid_q <= in_valid;
            memwb_rw_q    <= in_valid & in_RegWrite;
            memwb_rd_q    <= in_rd;
            memwb_wdata_q <= memwb_wdata_d;
        end else begin
            memwb_valid_q <= 1'b0;
            memwb_rw_q    <= 1'b0;
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;

    assign memwb_valid    = memwb_valid_q;
    assign memwb_RegWrite = memwb_rw_q;
    assign memwb_rd       = memwb_rd_q;
    assign memwb_wdata    = memwb_wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: Wishbone slave model with
// programmable wait states, reference memory, and scoreboards for bus
// transactions and MEM/WB results (value and arrival cycle).
module tb_mem_access_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_MemRead, in_MemWrite, in_MemtoReg, in_RegWrite, in_MemSize;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        stall_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        memwb_valid, memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_wdata;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_MemRead     (in_MemRead),
        .in_MemWrite    (in_MemWrite),
        .in_MemtoReg    (in_MemtoReg),
        .in_RegWrite    (in_RegWrite),
        .in_MemSize     (in_MemSize),
        .stall_o        (stall_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_sel_o       (wb_sel_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .memwb_valid    (memwb_valid),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_rd       (memwb_rd),
        .memwb_wdata    (memwb_wdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    logic [31:0] slv_mem [0:255];
    int unsigned slave_waits = 0;
    int unsigned wait_cnt = 0;
    logic        force_ack = 1'b0;

    assign wb_ack_i = force_ack | (wb_cyc_o & wb_stb_o & (wait_cnt == slave_waits));
    assign wb_dat_i = slv_mem[wb_adr_o[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= 0;
            for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
        end else begin
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i)
                for (int b = 0; b < 4; b++)
                    if (wb_sel_o[b]) slv_mem[wb_adr_o[9:2]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
        end
    end

    // ---------------- Scoreboards ----------------
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } bus_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } wb_t;

    bus_t        bus_q[$];
    wb_t         wb_q[$];
    int unsigned cyc_q[$];
    logic [31:0] ref_mem [0:255];

    int unsigned cyc_n = 0;
    logic        mon_en = 1'b0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic        prev_cyc = 1'b0;
    logic        prev_ack = 1'b0;
    bus_t        prev_bus;

    always @(negedge clk) begin
        bus_t        eb;
        bus_t        cur;
        wb_t         ew;
        int unsigned ec;
        if (reset && mon_en) begin
            cur = '{adr: wb_adr_o, dat: wb_dat_o, sel: wb_sel_o, we: wb_we_o};
            if (wb_cyc_o || wb_stb_o) check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            if (prev_cyc && prev_ack) check("idle_after_ack", wb_cyc_o, 1'b0);
            else if (prev_cyc && wb_cyc_o) check("bus_stable", cur, prev_bus);
            if (wb_cyc_o && wb_ack_i) begin
                if (bus_q.size() == 0) check("bus_unexpected", 1'b1, 1'b0);
                else begin
                    eb = bus_q.pop_front();
                    check("bus_adr_sel_we", {wb_adr_o, wb_sel_o, wb_we_o}, {eb.adr, eb.sel, eb.we});
                    if (eb.we) check("bus_wdat", wb_dat_o, eb.dat);
                end
            end
            if (memwb_valid) begin
                if (wb_q.size() == 0) check("memwb_unexpected", 1'b1, 1'b0);
                else begin
                    ew = wb_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("memwb_rw_rd_wdata", {memwb_RegWrite, memwb_rd, memwb_wdata}, ew);
                    check("memwb_latency", cyc_n, ec);
                end
            end else begin
                check("memwb_rw_bubble", memwb_RegWrite, 1'b0);
            end
            prev_cyc = wb_cyc_o;
            prev_ack = wb_cyc_o & wb_ack_i;
            prev_bus = cur;
        end else begin
            prev_cyc = 1'b0;
            prev_ack = 1'b0;
        end
    end

    function automatic logic [31:0] tb_load(input logic size, input logic [1:0] off, input logic [31:0] w);
        logic [7:0] b;
        b = 8'(w >> {off, 3'b000});
        return size ? {{24{b[7]}}, b} : w;
    endfunction

    // Drive one EX/MEM instruction starting just after a rising edge; returns
    // just after the edge on which EX/MEM advances.
    task automatic issue(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                         input logic size, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input int unsigned waits);
        logic        memop, isw;
        logic [3:0]  sel;
        logic [31:0] bdat, lv;
        logic [7:0]  idx;
        int unsigned stall_cnt;
        memop = rd_en | wr_en;
        isw   = wr_en & ~rd_en;
        sel   = size ? (4'b0001 << addr[1:0]) : 4'hF;
        bdat  = size ? {4{sdata[7:0]}} : sdata;
        idx   = addr[9:2];
        slave_waits   = waits;
        in_valid      = 1'b1;
        in_MemRead    = rd_en;
        in_MemWrite   = wr_en;
        in_MemtoReg   = m2r;
        in_RegWrite   = rw;
        in_MemSize    = size;
        in_alu_result = addr;
        in_store_data = sdata;
        in_rd         = rd;
        if (memop) bus_q.push_back('{adr: {addr[31:2], 2'b00}, dat: bdat, sel: sel, we: isw});
        if (isw)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][b*8 +: 8] = bdat[b*8 +: 8];
        lv = tb_load(size, addr[1:0], ref_mem[idx]);
        wb_q.push_back('{rw: rw, rd: rd, wdata: m2r ? lv : addr});
        cyc_q.push_back(cyc_n + (memop ? 3 + waits : 1));
        stall_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!stall_o) break;
            stall_cnt++;
        end
        check("stall_cycles", stall_cnt, memop ? waits + 2 : 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic bubble(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_MemRead = 0; in_MemWrite = 0; in_MemtoReg = 0;
        in_RegWrite = 0; in_MemSize = 0; in_alu_result = '0; in_store_data = '0; in_rd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, '0);
        check("rst_bus_adr_dat", {wb_adr_o, wb_dat_o}, '0);
        check("rst_memwb", {memwb_valid, memwb_RegWrite, memwb_rd, memwb_wdata}, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a long ACCESS, then a stray ack
        slave_waits = 10;
        in_valid = 1; in_MemRead = 1; in_MemtoReg = 1; in_RegWrite = 1;
        in_alu_result = 32'h8000_0104; in_rd = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, '0);
        check("midrst_memwb", {memwb_valid, memwb_RegWrite, memwb_rd, memwb_wdata}, '0);
        in_valid = 0; in_MemRead = 0; in_MemtoReg = 0; in_RegWrite = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        check("late_ack_cyc", wb_cyc_o, 1'b0);
        check("late_ack_memwb", {memwb_valid, memwb_RegWrite}, 2'b00);
        @(posedge clk);
        #1;
        check("late_ack_hold", {wb_cyc_o, memwb_valid, memwb_RegWrite}, 3'b000);
        mon_en = 1'b1;

        // ALU op
        issue(0, 0, 0, 1, MEM_SIZE_WORD, 32'h0000_1234, 32'h0, 5'd5, 0);
        bubble(1);
        // SW then LW, zero-wait
        issue(0, 1, 0, 0, MEM_SIZE_WORD, 32'h8000_0104, 32'hDEAD_BEEF, 5'd0, 0);
        bubble(1);
        issue(1, 0, 1, 1, MEM_SIZE_WORD, 32'h8000_0104, 32'h0, 5'd6, 0);
        bubble(1);
        // LB sign-extension
        issue(0, 1, 0, 0, MEM_SIZE_WORD, 32'h8000_0104, 32'h80FF_0011, 5'd0, 1);
        issue(1, 0, 1, 1, MEM_SIZE_BYTE, 32'h8000_0107, 32'h0, 5'd8, 0);
        issue(1, 0, 1, 1, MEM_SIZE_BYTE, 32'h8000_0104, 32'h0, 5'd9, 0);
        // SB with 3 wait states
        issue(0, 1, 0, 0, MEM_SIZE_BYTE, 32'h8000_0002, 32'h0000_00A5, 5'd3, 3);
        // SW immediately followed by LW
        issue(0, 1, 0, 0, MEM_SIZE_WORD, 32'h8000_0010, 32'h1357_9BDF, 5'd0, 2);
        issue(1, 0, 1, 1, MEM_SIZE_WORD, 32'h8000_0010, 32'h0, 5'd10, 2);
        // MemRead and MemWrite both set: read
        issue(1, 1, 1, 1, MEM_SIZE_WORD, 32'h8000_0106, 32'hFFFF_FFFF, 5'd11, 1);
        // LB of a byte written by SB
        issue(1, 0, 1, 1, MEM_SIZE_BYTE, 32'h8000_0002, 32'h0, 5'd12, 0);

        // Random mix
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a    = 32'h8000_0000 | 32'($urandom_range(0, 1023));
            case (kind)
                0: issue(0, 0, 0, 1'($urandom_range(0, 1)), MEM_SIZE_WORD, $urandom, 32'h0,
                         5'($urandom_range(0, 31)), 0);
                1: issue(0, 1, 0, 0, MEM_SIZE_WORD, a, $urandom, 5'd0, $urandom_range(0, 3));
                2: issue(0, 1, 0, 0, MEM_SIZE_BYTE, a, $urandom, 5'd0, $urandom_range(0, 3));
                3: issue(1, 0, 1, 1, MEM_SIZE_WORD, a, 32'h0, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
                default: issue(1, 0, 1, 1, MEM_SIZE_BYTE, a, 32'h0, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 2) == 0) bubble(1);
        end

        bubble(5);
        check("wb_queue_drained", wb_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
